// File: rtl/spi_coeff_rx.sv
// SPI mode-0 slave that deserialises one coefficient frame and checks its length and header.
// Latency: update_en/frame_err pulse SYNC_STAGES+2 clk edges after cs_n rises at the pin.
// Backpressure: none; the consumer must take data on update_en, and data is held until the next accepted frame.
module spi_coeff_rx #(
    parameter int          FRAME_BITS   = 336,
    parameter logic [15:0] HEADER       = 16'hA55A,
    parameter bit          CHECK_HEADER = 1'b1,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic [FRAME_BITS-1:0] data,
    output logic                  update_en,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    // Synchroniser chains, edge-detect history and registered strobes.
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, cs_prev_q;
    logic sck_rise_q, sck_rise_d;
    logic cs_fall_q,  cs_fall_d;
    logic cs_rise_q,  cs_rise_d;
    logic mosi_q,     mosi_d;
    logic sck_s, cs_s, mosi_s;

    // Frame state.
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]   data_q, data_d;
    logic                    update_en_q, update_en_d;
    logic                    frame_err_q, frame_err_d;
    logic                    header_ok;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Shift pins into the synchronisers and form the edge strobes; mosi is captured alongside the strobes so it lines up with sck_rise_q.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_rise_d  = sck_s & ~sck_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        mosi_d      = mosi_s;
    end

    // Synchroniser and strobe registers, reset to the idle pin levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            sck_rise_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            sck_rise_q  <= sck_rise_d;
            cs_fall_q   <= cs_fall_d;
            cs_rise_q   <= cs_rise_d;
            mosi_q      <= mosi_d;
        end
    end

    assign header_ok = !CHECK_HEADER || (shreg_q[FRAME_BITS-1 -: 16] == HEADER);

    // Frame FSM: cs edges take priority over sck so a closing sck edge is never shifted.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        update_en_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_fall_q) begin
                    // A fall without a seen rise restarts the frame silently.
                    bit_cnt_d = '0;
                end else if (cs_rise_q) begin
                    if (bit_cnt_q == FULL_CNT && header_ok) begin
                        data_d      = shreg_q;
                        update_en_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (sck_rise_q) begin
                    if (bit_cnt_q == FULL_CNT) begin
                        state_d = OVERRUN;
                    end else begin
                        shreg_d   = {shreg_q[FRAME_BITS-2:0], mosi_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            OVERRUN: begin
                if (cs_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            update_en_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            update_en_q <= update_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign update_en = update_en_q;
    assign frame_err = frame_err_q;

endmodule
